// File: rtl/jvm_byte_server.sv
// jvm_byte_server: serves big-endian bytecode bytes one at a time from a
// 32-bit synchronous program ROM. A one-word cache lets four consecutive
// bytes of the same word cost a single ROM fetch.
module jvm_byte_server #(
  parameter int SIZE          = 256,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pc_reset,
  output logic [7:0]               next_byte,
  output logic                     ready,
  output logic                     busy,
  output logic                     eop,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [31:0]              mem_rdata
);

  // The byte pointer carries one extra top bit so that the end-of-program
  // value SIZE*4 is representable; below that value the top bit is zero and
  // the word index / lane fields sit in the low ADDRESS_WIDTH+2 bits.
  localparam int BPW = ADDRESS_WIDTH + 3;
  localparam logic [BPW-1:0] END_BP = {1'b1, {(ADDRESS_WIDTH+2){1'b0}}};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] FILL    = 2'd2;
  localparam logic [1:0] DELIVER = 2'd3;

  // Elaboration-time guard on the parameter relationship.
  generate
    if (SIZE != (2 ** ADDRESS_WIDTH)) begin : g_size_check
      $error("jvm_byte_server: SIZE must equal 2**ADDRESS_WIDTH");
    end
  endgenerate

  logic [1:0]               state_reg;
  logic [BPW-1:0]           bp_reg;
  logic [31:0]              cache_data_reg;
  logic [ADDRESS_WIDTH-1:0] cache_tag_reg;
  logic                     cache_valid_reg;
  logic [7:0]               next_byte_reg;
  logic                     ready_reg;
  logic [ADDRESS_WIDTH-1:0] mem_addr_reg;

  logic [ADDRESS_WIDTH-1:0] bp_word;
  logic [1:0]               bp_lane;
  logic                     eop_now;
  logic                     cache_hit;

  // Big-endian lane pick: lane 0 is the most significant byte.
  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] l);
    logic [7:0] b;
    case (l)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign bp_word   = bp_reg[ADDRESS_WIDTH+1:2];
  assign bp_lane   = bp_reg[1:0];
  assign eop_now   = (bp_reg == END_BP);
  assign cache_hit = cache_valid_reg && (cache_tag_reg == bp_word);

  assign next_byte = next_byte_reg;
  assign ready     = ready_reg;
  assign busy      = (state_reg != IDLE);
  assign eop       = eop_now;
  assign mem_addr  = mem_addr_reg;

  // Request sequencer: cache lookup, ROM fetch, byte delivery and pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      bp_reg          <= '0;
      cache_data_reg  <= '0;
      cache_tag_reg   <= '0;
      cache_valid_reg <= 1'b0;
      next_byte_reg   <= 8'h00;
      ready_reg       <= 1'b0;
      mem_addr_reg    <= '0;
    end else if (pc_reset) begin
      // Rewind aborts any in-flight request; the cached word survives.
      state_reg <= IDLE;
      bp_reg    <= '0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b0;
          if (start) begin
            if (eop_now) begin
              // Past the end: answer with a zero byte, no ROM access.
              next_byte_reg <= 8'h00;
              ready_reg     <= 1'b1;
              state_reg     <= DELIVER;
            end else if (cache_hit) begin
              next_byte_reg <= lane_sel(cache_data_reg, bp_lane);
              ready_reg     <= 1'b1;
              state_reg     <= DELIVER;
            end else begin
              mem_addr_reg <= bp_word;
              state_reg    <= WAIT;
            end
          end
        end
        WAIT: begin
          // ROM is registering the address presented this cycle.
          state_reg <= FILL;
        end
        FILL: begin
          cache_data_reg  <= mem_rdata;
          cache_tag_reg   <= mem_addr_reg;
          cache_valid_reg <= 1'b1;
          next_byte_reg   <= lane_sel(mem_rdata, bp_lane);
          ready_reg       <= 1'b1;
          state_reg       <= DELIVER;
        end
        default: begin
          // DELIVER: ready is high this cycle; advance unless already at the end.
          ready_reg <= 1'b0;
          if (!eop_now) begin
            bp_reg <= bp_reg + 1'b1;
          end
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
